// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned FIFO_ARB_NUM_REQ    = 4;
  localparam int unsigned FIFO_ARB_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ARB_MAX_BURST  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = FIFO_ARB_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    int unsigned       cand;
    logic [IDX_W-1:0]  cand_idx;
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_LOCK_EN to hold a grant for up to MAX_BURST beats; otherwise one beat per grant.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = FIFO_ARB_NUM_REQ,
  parameter int unsigned DATA_WIDTH = FIFO_ARB_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = FIFO_ARB_MAX_BURST
) (
  input  logic                          Clk,
  input  logic                          Clear_in,
  input  logic [NUM_REQ-1:0]            Req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  input  logic                          Full_in,
  output logic [NUM_REQ-1:0]            Grant_out,
  output logic [DATA_WIDTH-1:0]         Fifo_Data_out,
  output logic                          Fifo_WriteEn_out,
  output logic                          Busy_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_write_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("fifo_write_arbiter: MAX_BURST must be 1..255");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             write_en;
  logic             last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (Req_in),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign owner_req = Req_in[owner_q];
  assign write_en  = (state_q == GRANT) && owner_req && !Full_in;
  assign ptr_d     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] cnt_q;

  // The beat that brings the count up to MAX_BURST is the last one of the grant.
  assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (pick_valid) cnt_q <= '0;
    end else if (write_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  // A dropped owner request releases even while full, so no beat is taken in that case.
  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || (write_en && last_beat)) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    Grant_out = '0;
    if (write_en) Grant_out[owner_q] = 1'b1;
  end

  assign Fifo_WriteEn_out = write_en;
  assign Fifo_Data_out    = (state_q == GRANT) ? Data_in[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign Busy_out         = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and random checks of fifo_write_arbiter against a cycle-level reference model.
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int LIMIT = 4;
`else
  localparam int LIMIT = 1;
`endif

  logic           Clk = 1'b0;
  logic           Clear_in;
  logic [N-1:0]   Req_in;
  logic [N*W-1:0] Data_in;
  logic           Full_in;
  logic [N-1:0]   Grant_out;
  logic [W-1:0]   Fifo_Data_out;
  logic           Fifo_WriteEn_out;
  logic           Busy_out;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W),
    .MAX_BURST  (4)
  ) dut (
    .Clk              (Clk),
    .Clear_in         (Clear_in),
    .Req_in           (Req_in),
    .Data_in          (Data_in),
    .Full_in          (Full_in),
    .Grant_out        (Grant_out),
    .Fifo_Data_out    (Fifo_Data_out),
    .Fifo_WriteEn_out (Fifo_WriteEn_out),
    .Busy_out         (Busy_out)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, where the rotation resumes, beats taken so far.
  bit m_busy;
  int m_own, m_ptr, m_beats;

  // Observation log: grant runs (owner, length, idle cycles before it) and written data.
  int           r_own[$];
  int           r_len[$];
  int           r_gap[$];
  int           idle_cnt;
  bit           prev_g;
  logic [W-1:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input int i);
    return Data_in[i*W +: W];
  endfunction

  task automatic set_data(input int i, input logic [W-1:0] v);
    Data_in[i*W +: W] = v;
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_ptr = 0; m_beats = 0;
  endtask

  task automatic model_step();
    bit found;
    int idx;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && Req_in[idx]) begin
          found = 1; m_busy = 1; m_own = idx; m_beats = 0;
        end
      end
    end else if (!Req_in[m_own]) begin
      m_busy = 0; m_ptr = (m_own + 1) % N;
    end else if (!Full_in) begin
      m_beats++;
      if (m_beats == LIMIT) begin
        m_busy = 0; m_ptr = (m_own + 1) % N;
      end
    end
  endtask

  task automatic clear_log();
    r_own.delete(); r_len.delete(); r_gap.delete(); wq.delete();
    idle_cnt = 0; prev_g = 0;
  endtask

  task automatic tick();
    logic [N-1:0] eg;
    logic         ewe;
    logic [W-1:0] ed;
    int           gi;
    @(negedge Clk);
    if (Clear_in) model_reset();
    ewe = m_busy && Req_in[m_own] && !Full_in;
    eg  = '0;
    if (ewe) eg[m_own] = 1'b1;
    ed  = m_busy ? slice(m_own) : '0;
    chk("grant", 32'(Grant_out), 32'(eg));
    chk("wen",   32'(Fifo_WriteEn_out), 32'(ewe));
    chk("data",  32'(Fifo_Data_out), 32'(ed));
    chk("busy",  32'(Busy_out), 32'(m_busy));
    gi = -1;
    for (int i = 0; i < N; i++) if (Grant_out[i]) gi = i;
    if (gi >= 0) begin
      if (!prev_g) begin
        r_own.push_back(gi); r_len.push_back(1); r_gap.push_back(idle_cnt);
      end else begin
        r_len[r_len.size()-1] = r_len[r_len.size()-1] + 1;
      end
      idle_cnt = 0; prev_g = 1;
    end else begin
      idle_cnt++; prev_g = 0;
    end
    if (Fifo_WriteEn_out) wq.push_back(Fifo_Data_out);
    @(posedge Clk);
    if (Clear_in) model_reset(); else model_step();
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) set_data(i, W'($urandom));
  endtask

  task automatic do_reset();
    Clear_in = 1'b1;
    tick(); tick();
    Clear_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_ord[5];
    int exp_pat[4];
    int nb, stall_after, stalled;

    Clear_in = 1'b1; Req_in = '0; Full_in = 1'b0; Data_in = '0;
    model_reset(); clear_log();
    #1;

    // Reset held with every requester asking: outputs stay quiet.
    Req_in = 4'b1111;
    rand_data();
    repeat (3) tick();
    chk("rst_grant", 32'(Grant_out), 32'd0);
    chk("rst_wen",   32'(Fifo_WriteEn_out), 32'd0);
    chk("rst_busy",  32'(Busy_out), 32'd0);

    // Rotation from requester 0 after reset.
    Clear_in = 1'b0; clear_log();
    for (int c = 0; c < 5*(LIMIT+1)+2; c++) begin rand_data(); tick(); end
    exp_ord = '{0, 1, 2, 3, 0};
    chk("order_cnt", 32'(r_own.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("order_own", 32'(r_own[i]), 32'(exp_ord[i]));
      chk("order_len", 32'(r_len[i]), 32'(LIMIT));
    end

    // Two requesters held: alternating runs of LIMIT beats separated by one idle cycle.
    do_reset(); clear_log();
`ifdef FIFO_ARB_BURST_LOCK_EN
    Req_in = 4'b0101;
    exp_pat = '{0, 2, 0, 2};
`else
    Req_in = 4'b0011;
    exp_pat = '{0, 1, 0, 1};
`endif
    for (int c = 0; c < 4*(LIMIT+1)+2; c++) begin rand_data(); tick(); end
    chk("alt_cnt", 32'(r_own.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("alt_own", 32'(r_own[i]), 32'(exp_pat[i]));
      chk("alt_len", 32'(r_len[i]), 32'(LIMIT));
      chk("alt_gap", 32'(r_gap[i]), 32'd1);
    end

    // Full stall in the middle of a grant: no beats lost, owner kept.
    Req_in = '0; tick(); tick();
    do_reset(); clear_log();
    Req_in = 4'b0001;
    nb = LIMIT;
    stall_after = (nb > 2) ? 2 : 0;
    stalled = 0;
    for (int c = 0; c < 40 && wq.size() < nb; c++) begin
      Full_in = (wq.size() == stall_after) && m_busy && (stalled < 3);
      if (Full_in) stalled++;
      set_data(0, 8'hA1 + W'(wq.size()));
      tick();
    end
    Full_in = 1'b0; Req_in = '0;
    chk("stall_cycles", 32'(stalled), 32'd3);
    chk("stall_beats",  32'(wq.size()), 32'(nb));
    for (int i = 0; i < nb; i++) chk("stall_data", 32'(wq[i]), 32'(8'hA1 + i));
    for (int i = 0; i < r_own.size(); i++) chk("stall_own", 32'(r_own[i]), 32'd0);
    tick(); tick();

    // Owner withdraws while full: release, no write, rotation resumes after it.
    clear_log();
    Req_in = 4'b0010; Full_in = 1'b1;
    rand_data();
    tick(); tick();
    Req_in = 4'b0000;
    tick();
    chk("drop_busy", 32'(Busy_out), 32'd0);
    chk("drop_nowrite", 32'(wq.size()), 32'd0);
    Req_in = 4'b0111; Full_in = 1'b0;
    tick(); tick();
    chk("drop_next_own", 32'(r_own[0]), 32'd2);
    Req_in = '0;
    tick(); tick();

    // Asynchronous clear in the middle of a grant to requester 2.
    clear_log();
    Req_in = 4'b0100;
    rand_data();
    tick();
    if (LIMIT > 1) tick();
    #2;
    Clear_in = 1'b1;
    #1;
    chk("aclr_grant", 32'(Grant_out), 32'd0);
    chk("aclr_wen",   32'(Fifo_WriteEn_out), 32'd0);
    chk("aclr_data",  32'(Fifo_Data_out), 32'd0);
    chk("aclr_busy",  32'(Busy_out), 32'd0);
    model_reset();
    tick();
    Clear_in = 1'b0; clear_log();
    Req_in = 4'b1111;
    tick(); tick(); tick();
    chk("aclr_restart", 32'(r_own[0]), 32'd0);

    // Random traffic with withdrawals, stalls and occasional clears.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!Req_in[i] && ($urandom % 4 == 0)) Req_in[i] = 1'b1;
        else if (Req_in[i] && ($urandom % 12 == 0)) Req_in[i] = 1'b0;
      end
      Full_in  = ($urandom % 4 == 0);
      Clear_in = ($urandom % 80 == 0);
      rand_data();
      tick();
    end
    Clear_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
